// File: rtl/branch_predictor_btb.sv
// Branch target buffer with 2-bit direction counters.
// Predicts next-PC at fetch, trains and flags mispredicts at execute.
module branch_predictor_btb #(
  parameter int         ENTRIES  = 16,
  parameter int         TAG_W    = 26,
  parameter logic [1:0] INIT_CTR = 2'b10
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        lookup_valid,
  input  logic [31:0] lookup_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        resolve_valid,
  input  logic [31:0] resolve_pc,
  input  logic        resolve_taken,
  input  logic [31:0] resolve_target,
  input  logic        resolve_pred_taken,
  input  logic [31:0] resolve_pred_target,
  input  logic        invalidate,
  output logic        redirect_en,
  output logic [31:0] redirect_pc,
  output logic        flush_fetch,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];

  logic [IDX_W-1:0] l_idx;
  logic [TAG_W-1:0] l_tag;
  logic [IDX_W-1:0] r_idx;
  logic [TAG_W-1:0] r_tag;
  logic             r_hit;
  logic             mis;
  logic [31:0]      l_pc4;
  logic [31:0]      r_pc4;
  logic             unused_ok;

  assign unused_ok = ^{lookup_pc[1:0], resolve_pc[1:0]};

  assign l_idx = lookup_pc[2 +: IDX_W];
  assign l_tag = lookup_pc[2+IDX_W +: TAG_W];
  assign r_idx = resolve_pc[2 +: IDX_W];
  assign r_tag = resolve_pc[2+IDX_W +: TAG_W];
  assign l_pc4 = lookup_pc + 32'd4;
  assign r_pc4 = resolve_pc + 32'd4;

  // Fetch-side prediction, reads pre-update contents.
  always_comb begin
    pred_hit    = lookup_valid & valid_q[l_idx]
                & (tag_q[l_idx] == l_tag);
    pred_taken  = pred_hit & ctr_q[l_idx][1];
    pred_target = pred_taken ? tgt_q[l_idx] : l_pc4;
  end

  // Execute-side mispredict detection and redirect.
  always_comb begin
    r_hit = valid_q[r_idx] & (tag_q[r_idx] == r_tag);
    mis   = resolve_valid
          & ((resolve_taken != resolve_pred_taken)
          | (resolve_taken & resolve_pred_taken
          & (resolve_target != resolve_pred_target)));
    redirect_en = mis;
    flush_fetch = mis;
    redirect_pc = '0;
    if (mis)
      redirect_pc = resolve_taken ? resolve_target : r_pc4;
  end

  // Table training; invalidate wins over any same-cycle update.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= '0;
      end
    end else if (invalidate) begin
      valid_q <= '0;
    end else if (resolve_valid) begin
      if (r_hit) begin
        if (resolve_taken) begin
          tgt_q[r_idx] <= resolve_target;
          if (ctr_q[r_idx] != 2'b11)
            ctr_q[r_idx] <= ctr_q[r_idx] + 2'd1;
        end else if (ctr_q[r_idx] != 2'b00) begin
          ctr_q[r_idx] <= ctr_q[r_idx] - 2'd1;
        end
      end else if (resolve_taken) begin
        valid_q[r_idx] <= 1'b1;
        tag_q[r_idx]   <= r_tag;
        tgt_q[r_idx]   <= resolve_target;
        ctr_q[r_idx]   <= INIT_CTR;
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (resolve_valid && stat_branches != '1)
        stat_branches <= stat_branches + 32'd1;
      if (mis && stat_mispredicts != '1)
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end

endmodule
